// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp port
module axil_cmd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    axil_cmd_master_if.master     m_axil
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ,
        READ_RESP,
        RSP
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [2:0]            prot_q, prot_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    // Every output is either a flop or a decode of flops, so no input reaches an output combinationally.
    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = (state_q == RSP);
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = prot_q;
    assign m_axil.awvalid = (state_q == WRITE) && !aw_done_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = (state_q == WRITE) && !w_done_q;
    assign m_axil.bready  = (state_q == WRITE_RESP);
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = prot_q;
    assign m_axil.arvalid = (state_q == READ);
    assign m_axil.rready  = (state_q == READ_RESP);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q gates acceptance so the first edge after reset release cannot take a command.
                if (cmd_valid && cmd_ready_q) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    prot_d    = cmd_prot;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (m_axil.awvalid && m_axil.awready) begin
                    aw_done_d = 1'b1;
                end
                if (m_axil.wvalid && m_axil.wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WRITE_RESP;
                end
            end
            WRITE_RESP: begin
                if (m_axil.bvalid) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axil.bresp;
                    state_d     = RSP;
                end
            end
            READ: begin
                if (m_axil.arready) begin
                    state_d = READ_RESP;
                end
            end
            READ_RESP: begin
                if (m_axil.rvalid) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axil.rdata;
                    rsp_resp_d  = m_axil.rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - scoreboard bench for axil_cmd_master with a delay-configurable RAM slave
module tb_axil_cmd_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    always #5 clk = ~clk;

    axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) axi ();

    axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axil    (axi)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Slave: small RAM, per-channel ready/response delays set by the stimulus.
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'd0;
    logic [1:0] rresp_cfg = 2'd0;
    logic       aw_got, w_got, ar_got;
    int         aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [AW-1:0] aw_addr_s, ar_addr_s;
    logic [DW-1:0] w_data_s;
    logic [SW-1:0] w_strb_s;
    logic [DW-1:0] mem [16];

    assign axi.awready = !aw_got && (aw_cnt >= aw_delay);
    assign axi.wready  = !w_got && (w_cnt >= w_delay);
    assign axi.bvalid  = aw_got && w_got && (b_cnt >= b_delay);
    assign axi.bresp   = bresp_cfg;
    assign axi.arready = !ar_got && (ar_cnt >= ar_delay);
    assign axi.rvalid  = ar_got && (r_cnt >= r_delay);
    assign axi.rdata   = mem[ar_addr_s[5:2]];
    assign axi.rresp   = rresp_cfg;

    always @(posedge clk) begin
        if (!rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_addr_s <= '0; ar_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                aw_got <= 1'b1; aw_addr_s <= axi.awaddr; aw_cnt <= 0;
            end else if (axi.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_got <= 1'b1; w_data_s <= axi.wdata; w_strb_s <= axi.wstrb; w_cnt <= 0;
            end else if (axi.wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !axi.bvalid) b_cnt <= b_cnt + 1;
            if (axi.bvalid && axi.bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                for (int i = 0; i < SW; i++)
                    if (w_strb_s[i]) mem[aw_addr_s[5:2]][8*i +: 8] <= w_data_s[8*i +: 8];
            end
            if (axi.arvalid && axi.arready) begin
                ar_got <= 1'b1; ar_addr_s <= axi.araddr; ar_cnt <= 0;
            end else if (axi.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (ar_got && !axi.rvalid) r_cnt <= r_cnt + 1;
            if (axi.rvalid && axi.rready) begin
                ar_got <= 1'b0; r_cnt <= 0;
            end
        end
    end

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] rd;
        logic [1:0]    rs;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [SW-1:0] cur_wstrb = '0;
    logic [2:0]    cur_prot = '0;

    // Monitor: bus payload, channel ordering and response payload against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (axi.awvalid) begin
                check("awaddr", axi.awaddr, cur_addr);
                check("awprot", axi.awprot, cur_prot);
            end
            if (axi.wvalid) begin
                check("wdata", axi.wdata, cur_wdata);
                check("wstrb", axi.wstrb, cur_wstrb);
            end
            if (axi.arvalid) begin
                check("araddr", axi.araddr, cur_addr);
                check("arprot", axi.arprot, cur_prot);
            end
            if (aw_got) check("awvalid_after_hs", axi.awvalid, 1'b0);
            if (w_got) check("wvalid_after_hs", axi.wvalid, 1'b0);
            if (axi.bready) check("bready_before_aw_w", {aw_got, w_got}, 2'b11);
            if (axi.rready) check("rready_before_ar", ar_got, 1'b1);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    check("rsp_write", rsp_write, sb_q[0].wr);
                    check("rsp_rdata", rsp_rdata, sb_q[0].rd);
                    check("rsp_resp", rsp_resp, sb_q[0].rs);
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p, input logic [DW-1:0] erd,
                          input logic [1:0] ers, input int elat, input int hold);
        logic ok;
        int   lat;
        exp_t e;
        @(posedge clk);
        #1;
        cur_addr = a; cur_wdata = d; cur_wstrb = s; cur_prot = p;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        check("cmd_ready_wait", ok, 1'b1);
        if (!ok) begin cmd_valid = 1'b0; rsp_ready = 1'b1; return; end
        @(posedge clk);
        e.wr = wr; e.rd = erd; e.rs = ers;
        sb_q.push_back(e);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        check("valids_at_n1", {axi.awvalid, axi.wvalid, axi.arvalid}, wr ? 3'b110 : 3'b001);
        check("cmd_ready_busy", cmd_ready, 1'b0);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, elat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("cmd_ready_during_hold", cmd_ready, 1'b0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
            check("cmd_ready_same_cycle_as_rsp_ready", cmd_ready, 1'b0);
        end
        @(negedge clk);
        check("cmd_ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid, cmd_ready}, 7'd0);
        check("reset_rsp_payload", {rsp_rdata, rsp_resp}, 34'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_release_cycle", cmd_ready, 1'b0);
        @(negedge clk);
        check("cmd_ready_after_release", cmd_ready, 1'b1);

        do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 2'd0, 3, 0);
        do_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, 32'hDEADBEEF, 2'd0, 3, 0);

        aw_delay = 3;
        do_cmd(1'b1, 16'h0008, 32'hA5A50001, 4'hF, 3'd2, 32'h0, 2'd0, 6, 0);
        aw_delay = 0;

        w_delay = 2;
        do_cmd(1'b1, 16'h000C, 32'h0BADF00D, 4'hC, 3'd1, 32'h0, 2'd0, 5, 0);
        w_delay = 0;

        ar_delay = 1; r_delay = 2;
        do_cmd(1'b0, 16'h000C, 32'h0, 4'h0, 3'd5, 32'h0BAD0000, 2'd0, 6, 0);
        ar_delay = 0; r_delay = 0;

        b_delay = 2; bresp_cfg = 2'd3;
        do_cmd(1'b1, 16'h0010, 32'h11223344, 4'h1, 3'd0, 32'h0, 2'd3, 5, 0);
        b_delay = 0; bresp_cfg = 2'd0;

        rresp_cfg = 2'd2;
        do_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 3'd0, 32'hDEADBE44, 2'd2, 3, 5);
        rresp_cfg = 2'd0;

        // Reset while AW is stalled by the slave.
        aw_delay = 10;
        @(posedge clk);
        #1;
        cur_addr = 16'h0020; cur_wdata = 32'hCAFE0000; cur_wstrb = 4'hF; cur_prot = 3'd0;
        cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'hCAFE0000; cmd_wstrb = 4'hF; cmd_prot = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_write_awvalid", {axi.awvalid, axi.awready}, 2'b10);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_outputs", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid, cmd_ready}, 7'd0);
        sb_q.delete();
        aw_delay = 0;
        @(negedge clk);
        check("mid_reset_cmd_ready_held", cmd_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_reset_release_cycle", cmd_ready, 1'b0);
        @(negedge clk);
        check("mid_reset_cmd_ready_back", cmd_ready, 1'b1);

        do_cmd(1'b1, 16'h0004, 32'h12345678, 4'h3, 3'd0, 32'h0, 2'd0, 3, 0);
        do_cmd(1'b0, 16'h0004, 32'h0, 4'h0, 3'd0, 32'h00005678, 2'd0, 3, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
